// File: rtl/ope_fetch_decoder.sv
// ---------------------------------------------------------------------------
// ope_fetch_decoder
//
// Byte-serial instruction fetcher for a small x86-like opcode subset. It
// issues one byte read at a time, decodes the length from the opcode (and
// the ModRM byte where one follows), assembles up to four bytes into a
// 32-bit word and presents it with a valid/ready handshake.
//
// Optional feature: define DECODE_ILLEGAL_TRAP_EN to flag unknown opcodes
// on the 'illegal' port and halt fetching after handing the opcode over,
// until a redirect arrives. Without the macro, unknown opcodes are treated
// as 1-byte instructions and the 'illegal' port does not exist.
//
// Ports
//   clock, reset_n       : clock, async active-low reset
//   mem_req/mem_addr     : byte read request (held until mem_ack)
//   mem_ack/mem_data     : read completion with the byte
//   ope, num_of_ope      : assembled instruction (byte0 in [31:24]) and length
//   ope_pc, ope_valid    : address of byte0, output qualifier
//   ope_ready            : consumer accepts the instruction
//   redirect/redirect_pc : one-cycle pulse loading a new fetch address
//   illegal              : unknown-opcode flag (DECODE_ILLEGAL_TRAP_EN only)
// ---------------------------------------------------------------------------
module ope_fetch_decoder #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic [31:0] ope,
    output logic [3:0]  num_of_ope,
    output logic [31:0] ope_pc,
    output logic        ope_valid,
    input  logic        ope_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    output logic        illegal
`endif
);

    typedef enum logic [2:0] {
        FETCH_OP,
        FETCH_MODRM,
        FETCH_REST,
        HOLD
`ifdef DECODE_ILLEGAL_TRAP_EN
        ,
        HALT
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ope_q, ope_d;
    logic [31:0] ope_pc_q, ope_pc_d;
    logic [3:0]  num_q, num_d;
    logic        valid_q, valid_d;
    logic        mem_req_q, mem_req_d;
    logic [2:0]  cnt_q, cnt_d;   // index of the byte being fetched in FETCH_REST
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic        illegal_q, illegal_d;
`endif

    logic        ack_ok;
    logic [3:0]  op_len;
    logic [3:0]  modrm_len_w;
    logic        rest_last;

    // Length implied by byte0 alone; 0 means a ModRM byte decides it.
    function automatic logic [3:0] base_len(input logic [7:0] b);
        case (b)
            8'h55, 8'h53, 8'h5d, 8'hc3, 8'hc9: base_len = 4'd1;
            8'h6a:                             base_len = 4'd2;
            8'hb8, 8'he8:                      base_len = 4'd5;
            8'h89, 8'h8b, 8'h83:               base_len = 4'd0;
            default:                           base_len = 4'd1;
        endcase
    endfunction

    // Register form (mod=11) has no displacement; every other mod is
    // decoded as a one-byte displacement.
    function automatic logic [3:0] modrm_len(input logic [7:0] op, input logic [7:0] m);
        logic reg_form;
        reg_form = (m[7:6] == 2'b11);
        if (op == 8'h83) modrm_len = reg_form ? 4'd3 : 4'd4;
        else             modrm_len = reg_form ? 4'd2 : 4'd3;
    endfunction

`ifdef DECODE_ILLEGAL_TRAP_EN
    function automatic logic is_known(input logic [7:0] b);
        case (b)
            8'h55, 8'h53, 8'h5d, 8'hc3, 8'hc9,
            8'h6a, 8'hb8, 8'he8,
            8'h89, 8'h8b, 8'h83: is_known = 1'b1;
            default:             is_known = 1'b0;
        endcase
    endfunction
`endif

    // An ack only counts against a request we actually raised.
    assign ack_ok      = mem_req_q & mem_ack;
    assign op_len      = base_len(mem_data);
    assign modrm_len_w = modrm_len(ope_q[31:24], mem_data);
    assign rest_last   = (({1'b0, cnt_q} + 4'd1) == num_q);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ope_d     = ope_q;
        ope_pc_d  = ope_pc_q;
        num_d     = num_q;
        valid_d   = valid_q;
        mem_req_d = mem_req_q;
        cnt_d     = cnt_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif

        if (redirect) begin
            // Overrides everything, including a same-cycle ack (dropped) and
            // a same-cycle handshake (already taken by the consumer).
            state_d   = FETCH_OP;
            pc_d      = redirect_pc;
            valid_d   = 1'b0;
            cnt_d     = 3'd0;
            mem_req_d = 1'b1;
`ifdef DECODE_ILLEGAL_TRAP_EN
            illegal_d = 1'b0;
`endif
        end else begin
            case (state_q)
                FETCH_OP: begin
                    mem_req_d = 1'b1;
                    if (ack_ok) begin
                        pc_d     = pc_q + 32'd1;
                        ope_d    = {mem_data, 24'h0};
                        ope_pc_d = pc_q;
                        cnt_d    = 3'd1;
                        if (op_len == 4'd0) begin
                            num_d   = 4'd0;
                            state_d = FETCH_MODRM;
                        end else if (op_len == 4'd1) begin
                            num_d     = 4'd1;
                            state_d   = HOLD;
                            valid_d   = 1'b1;
                            mem_req_d = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
                            illegal_d = ~is_known(mem_data);
`endif
                        end else begin
                            num_d   = op_len;
                            state_d = FETCH_REST;
                        end
                    end
                end

                FETCH_MODRM: begin
                    mem_req_d = 1'b1;
                    if (ack_ok) begin
                        pc_d         = pc_q + 32'd1;
                        ope_d[23:16] = mem_data;
                        num_d        = modrm_len_w;
                        cnt_d        = 3'd2;
                        if (modrm_len_w == 4'd2) begin
                            state_d   = HOLD;
                            valid_d   = 1'b1;
                            mem_req_d = 1'b0;
                        end else begin
                            state_d = FETCH_REST;
                        end
                    end
                end

                FETCH_REST: begin
                    mem_req_d = 1'b1;
                    if (ack_ok) begin
                        pc_d = pc_q + 32'd1;
                        // Byte 4 of a 5-byte instruction has no slot.
                        case (cnt_q)
                            3'd1:    ope_d[23:16] = mem_data;
                            3'd2:    ope_d[15:8]  = mem_data;
                            3'd3:    ope_d[7:0]   = mem_data;
                            default: ;
                        endcase
                        if (rest_last) begin
                            state_d   = HOLD;
                            valid_d   = 1'b1;
                            mem_req_d = 1'b0;
                            cnt_d     = 3'd0;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end

                HOLD: begin
                    mem_req_d = 1'b0;
                    if (ope_ready) begin
                        valid_d = 1'b0;
                        cnt_d   = 3'd0;
`ifdef DECODE_ILLEGAL_TRAP_EN
                        illegal_d = 1'b0;
                        state_d   = illegal_q ? HALT : FETCH_OP;
                        mem_req_d = ~illegal_q;
`else
                        state_d   = FETCH_OP;
                        mem_req_d = 1'b1;
`endif
                    end
                end

`ifdef DECODE_ILLEGAL_TRAP_EN
                HALT: begin
                    // Parked until a redirect.
                    mem_req_d = 1'b0;
                end
`endif

                default: begin
                    state_d   = FETCH_OP;
                    mem_req_d = 1'b0;
                    valid_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= FETCH_OP;
            pc_q      <= RESET_PC;
            ope_q     <= 32'h0;
            ope_pc_q  <= 32'h0;
            num_q     <= 4'd0;
            valid_q   <= 1'b0;
            mem_req_q <= 1'b0;
            cnt_q     <= 3'd0;
`ifdef DECODE_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ope_q     <= ope_d;
            ope_pc_q  <= ope_pc_d;
            num_q     <= num_d;
            valid_q   <= valid_d;
            mem_req_q <= mem_req_d;
            cnt_q     <= cnt_d;
`ifdef DECODE_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_addr   = pc_q;
    assign ope        = ope_q;
    assign num_of_ope = num_q;
    assign ope_pc     = ope_pc_q;
    assign ope_valid  = valid_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign illegal    = illegal_q;
`endif

endmodule

// File: tb/tb_ope_fetch_decoder.sv
// Testbench for ope_fetch_decoder: directed scenarios plus a randomized run
// scored against a byte-level decode model of the instruction set.
module tb_ope_fetch_decoder;

    logic        clock;
    logic        reset_n;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_data;
    logic [31:0] ope;
    logic [3:0]  num_of_ope;
    logic [31:0] ope_pc;
    logic        ope_valid;
    logic        ope_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    int checks = 0;
    int errors = 0;
    int ack_pct = 100;
    logic [7:0] mem [256];

    ope_fetch_decoder #(.RESET_PC(32'h0)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .ope         (ope),
        .num_of_ope  (num_of_ope),
        .ope_pc      (ope_pc),
        .ope_valid   (ope_valid),
        .ope_ready   (ope_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
`ifdef DECODE_ILLEGAL_TRAP_EN
        ,
        .illegal     (illegal)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory device: answers an open request with a random latency.
    always @(negedge clock) begin
        if (reset_n && mem_req && ($urandom_range(99) < ack_pct)) begin
            mem_ack  = 1'b1;
            mem_data = mem[mem_addr[7:0]];
        end else begin
            mem_ack  = 1'b0;
            mem_data = 8'($urandom);
        end
    end

    // Reference decode straight from the instruction-set rules.
    function automatic void model_decode(input logic [31:0] a, output int len,
                                         output logic [31:0] op, output bit ill);
        logic [7:0] b [5];
        for (int i = 0; i < 5; i++) b[i] = mem[8'(a + 32'(i))];
        ill = 1'b0;
        case (b[0])
            8'h55, 8'h53, 8'h5d, 8'hc3, 8'hc9: len = 1;
            8'h6a:                             len = 2;
            8'hb8, 8'he8:                      len = 5;
            8'h89, 8'h8b: len = (b[1][7:6] == 2'b11) ? 2 : 3;
            8'h83:        len = (b[1][7:6] == 2'b11) ? 3 : 4;
            default: begin len = 1; ill = 1'b1; end
        endcase
        op = 32'h0;
        for (int i = 0; i < 4; i++)
            if (i < len) op = op | (32'(b[i]) << (24 - 8 * i));
    endfunction

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (ope_valid) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (mem_req) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic do_redirect(input logic [31:0] a);
        redirect    = 1'b1;
        redirect_pc = a;
        tick();
        redirect    = 1'b0;
    endtask

    task automatic put(input logic [31:0] a, input logic [39:0] bytes, input int n);
        for (int i = 0; i < n; i++) mem[8'(a + 32'(i))] = bytes[39 - 8 * i -: 8];
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if ({mem_req, ope_valid, ope, num_of_ope, ope_pc} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b vld=%b ope=%h num=%0d pc=%h, want all zero",
                     mem_req, ope_valid, ope, num_of_ope, ope_pc);
        end
`ifdef DECODE_ILLEGAL_TRAP_EN
        checks++;
        if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", illegal); end
`endif
        reset_n = 1'b1;
        tick();
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL reset_first_req: req=%b addr=%h want req=1 addr=0", mem_req, mem_addr);
        end
    endtask

    task automatic test_basic();
        bit ok;
        wait_valid(ok);
        checks++;
        if (!ok || {ope, num_of_ope, ope_pc} !== {32'h55000000, 4'd1, 32'h0}) begin
            errors++;
            $display("FAIL basic_first: ok=%b ope=%h num=%0d pc=%h want 55000000/1/0", ok, ope, num_of_ope, ope_pc);
        end
        tick();
        checks++;
        if (ope_valid !== 1'b0) begin errors++; $display("FAIL basic_gap: valid=%b want 0", ope_valid); end
        wait_valid(ok);
        checks++;
        if (!ok || {ope, num_of_ope, ope_pc} !== {32'h89e50000, 4'd2, 32'h1}) begin
            errors++;
            $display("FAIL basic_second: ok=%b ope=%h num=%0d pc=%h want 89e50000/2/1", ok, ope, num_of_ope, ope_pc);
        end
    endtask

    task automatic test_long();
        bit ok;
        put(32'h10, 40'he8eeffffff, 5);
        ope_ready = 1'b1;
        do_redirect(32'h10);
        wait_valid(ok);
        checks++;
        if (!ok || {ope, num_of_ope, ope_pc} !== {32'he8eeffff, 4'd5, 32'h10}) begin
            errors++;
            $display("FAIL long_ope: ok=%b ope=%h num=%0d pc=%h want e8eeffff/5/10", ok, ope, num_of_ope, ope_pc);
        end
        tick();
        wait_req(ok);
        checks++;
        if (!ok || mem_addr !== 32'h15) begin
            errors++;
            $display("FAIL long_next_addr: ok=%b addr=%h want 15", ok, mem_addr);
        end
    endtask

    task automatic test_modrm();
        bit ok;
        put(32'h20, 40'h837dfc008b, 5);
        put(32'h25, 40'h45fc000000, 2);
        ope_ready = 1'b1;
        do_redirect(32'h20);
        wait_valid(ok);
        checks++;
        if (!ok || {ope, num_of_ope, ope_pc} !== {32'h837dfc00, 4'd4, 32'h20}) begin
            errors++;
            $display("FAIL modrm_83: ok=%b ope=%h num=%0d pc=%h want 837dfc00/4/20", ok, ope, num_of_ope, ope_pc);
        end
        tick();
        wait_valid(ok);
        checks++;
        if (!ok || {ope, num_of_ope, ope_pc} !== {32'h8b45fc00, 4'd3, 32'h24}) begin
            errors++;
            $display("FAIL modrm_8b: ok=%b ope=%h num=%0d pc=%h want 8b45fc00/3/24", ok, ope, num_of_ope, ope_pc);
        end
    endtask

    task automatic test_hold();
        bit ok;
        put(32'h30, 40'hb801020304, 5);
        ope_ready = 1'b0;
        do_redirect(32'h30);
        wait_valid(ok);
        checks++;
        if (!ok || {ope, num_of_ope, ope_pc} !== {32'hb8010203, 4'd5, 32'h30}) begin
            errors++;
            $display("FAIL hold_ope: ok=%b ope=%h num=%0d pc=%h want b8010203/5/30", ok, ope, num_of_ope, ope_pc);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({ope_valid, ope, mem_req} !== {1'b1, 32'hb8010203, 1'b0}) begin
                errors++;
                $display("FAIL hold_stable[%0d]: vld=%b ope=%h req=%b want 1/b8010203/0", i, ope_valid, ope, mem_req);
            end
        end
        ope_ready = 1'b1;
        tick();
        wait_req(ok);
        checks++;
        if (!ok || mem_addr !== 32'h35) begin
            errors++;
            $display("FAIL hold_restart: ok=%b addr=%h want 35", ok, mem_addr);
        end
    endtask

    task automatic test_redirect();
        bit ok;
        bit found;
        put(32'h50, 40'hb811223344, 5);
        mem[8'h40] = 8'h53;
        ope_ready = 1'b1;
        do_redirect(32'h50);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mem_req && mem_addr == 32'h52) begin found = 1'b1; break; end
            tick();
        end
        checks++;
        if (!found) begin errors++; $display("FAIL redir_reach_byte2: timeout, addr=%h want 52", mem_addr); end
        do_redirect(32'h40);
        checks++;
        if ({ope_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h40}) begin
            errors++;
            $display("FAIL redir_next_addr: vld=%b req=%b addr=%h want 0/1/40", ope_valid, mem_req, mem_addr);
        end
        wait_valid(ok);
        checks++;
        if (!ok || {ope, ope_pc} !== {32'h53000000, 32'h40}) begin
            errors++;
            $display("FAIL redir_first_ope: ok=%b ope=%h pc=%h want 53000000/40", ok, ope, ope_pc);
        end
    endtask

    task automatic test_handshake_redirect();
        bit ok;
        mem[8'h70] = 8'h55;
        mem[8'h78] = 8'hc3;
        ope_ready = 1'b1;
        do_redirect(32'h70);
        wait_valid(ok);
        do_redirect(32'h78);  // same cycle as the handshake
        checks++;
        if (!ok || {ope_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h78}) begin
            errors++;
            $display("FAIL hs_redir: ok=%b vld=%b req=%b addr=%h want 0/1/78", ok, ope_valid, mem_req, mem_addr);
        end
        wait_valid(ok);
        checks++;
        if (!ok || {ope, ope_pc} !== {32'hc3000000, 32'h78}) begin
            errors++;
            $display("FAIL hs_redir_ope: ok=%b ope=%h pc=%h want c3000000/78", ok, ope, ope_pc);
        end
    endtask

    task automatic test_illegal();
        bit ok;
        mem[8'h60] = 8'h0f;
        mem[8'h61] = 8'h5d;
        ope_ready = 1'b1;
        do_redirect(32'h60);
        wait_valid(ok);
        checks++;
        if (!ok || {ope, num_of_ope, ope_pc} !== {32'h0f000000, 4'd1, 32'h60}) begin
            errors++;
            $display("FAIL illegal_ope: ok=%b ope=%h num=%0d pc=%h want 0f000000/1/60", ok, ope, num_of_ope, ope_pc);
        end
`ifdef DECODE_ILLEGAL_TRAP_EN
        checks++;
        if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag: got %b want 1", illegal); end
        tick();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({mem_req, ope_valid} !== 2'b00) begin
                errors++;
                $display("FAIL illegal_halt[%0d]: req=%b vld=%b want 0/0", i, mem_req, ope_valid);
            end
            tick();
        end
        do_redirect(32'h61);
`else
        tick();
`endif
        wait_valid(ok);
        checks++;
        if (!ok || {ope, ope_pc} !== {32'h5d000000, 32'h61}) begin
            errors++;
            $display("FAIL illegal_resume: ok=%b ope=%h pc=%h want 5d000000/61", ok, ope, ope_pc);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        put(32'hfffffffe, 40'he801020304, 5);
        ope_ready = 1'b1;
        do_redirect(32'hfffffffe);
        wait_valid(ok);
        checks++;
        if (!ok || {ope, num_of_ope, ope_pc} !== {32'he8010203, 4'd5, 32'hfffffffe}) begin
            errors++;
            $display("FAIL wrap_ope: ok=%b ope=%h num=%0d pc=%h want e8010203/5/fffffffe", ok, ope, num_of_ope, ope_pc);
        end
        tick();
        wait_req(ok);
        checks++;
        if (!ok || mem_addr !== 32'h3) begin
            errors++;
            $display("FAIL wrap_next_addr: ok=%b addr=%h want 3", ok, mem_addr);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        put(32'h10, 40'he8eeffffff, 5);
        do_redirect(32'h10);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req && mem_ack) begin found = 1'b1; break; end
            tick();
        end
        reset_n = 1'b0;  // ack still pending
        #1;
        checks++;
        if (!found || {mem_req, ope_valid} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_abandon: found=%b req=%b vld=%b want req=0 vld=0", found, mem_req, ope_valid);
        end
        tick();
        checks++;
        if ({mem_req, ope_valid, ope, num_of_ope, ope_pc, mem_addr} !== '0) begin
            errors++;
            $display("FAIL rst_mid_state: req=%b vld=%b ope=%h num=%0d pc=%h addr=%h want zeros",
                     mem_req, ope_valid, ope, num_of_ope, ope_pc, mem_addr);
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL rst_mid_restart: req=%b addr=%h want 1/0", mem_req, mem_addr);
        end
    endtask

    task automatic test_random();
        int          len;
        logic [31:0] op;
        bit          ill;
        logic [31:0] inst_exp, fetch_exp, tgt;
        logic [31:0] s_ope, s_pc;
        logic [3:0]  s_num;
        bit          hold_prev, halted;
        int          pick;
        logic [7:0]  ops [11];
        ops = '{8'h55, 8'h53, 8'h5d, 8'hc3, 8'hc9, 8'h6a, 8'hb8, 8'he8, 8'h89, 8'h8b, 8'h83};
        for (int i = 0; i < 256; i++) begin
            pick = $urandom_range(11);
            mem[i] = (pick == 11) ? 8'($urandom) : ops[pick];
        end
        ack_pct   = 60;
        ope_ready = 1'b1;
        do_redirect(32'h80);
        inst_exp  = 32'h80;
        fetch_exp = 32'h80;
        hold_prev = 1'b0;
        halted    = 1'b0;
        s_ope = '0; s_pc = '0; s_num = '0;
        repeat (3000) begin
            if (hold_prev) begin
                checks++;
                if ({ope_valid, ope, num_of_ope, ope_pc} !== {1'b1, s_ope, s_num, s_pc}) begin
                    errors++;
                    $display("FAIL rnd_hold_stable: vld=%b ope=%h num=%0d pc=%h want 1/%h/%0d/%h",
                             ope_valid, ope, num_of_ope, ope_pc, s_ope, s_num, s_pc);
                end
            end
            if (ope_valid) begin
                checks++;
                if (mem_req !== 1'b0) begin errors++; $display("FAIL rnd_req_in_hold: req=%b want 0", mem_req); end
            end
            if (halted) begin
                checks++;
                if ({mem_req, ope_valid} !== 2'b00) begin
                    errors++;
                    $display("FAIL rnd_halted: req=%b vld=%b want 0/0", mem_req, ope_valid);
                end
            end
            ope_ready   = ($urandom_range(3) != 0);
            redirect    = ($urandom_range(24) == 0);
            tgt         = ($urandom_range(3) == 0) ? (32'hffffff00 | 32'($urandom_range(255)))
                                                   : 32'($urandom_range(255));
            redirect_pc = tgt;
            if (ope_valid && ope_ready) begin
                model_decode(inst_exp, len, op, ill);
                checks++;
                if ({ope, num_of_ope, ope_pc} !== {op, 4'(len), inst_exp}) begin
                    errors++;
                    $display("FAIL rnd_ope: ope=%h num=%0d pc=%h want %h/%0d/%h",
                             ope, num_of_ope, ope_pc, op, len, inst_exp);
                end
`ifdef DECODE_ILLEGAL_TRAP_EN
                checks++;
                if (illegal !== ill) begin errors++; $display("FAIL rnd_illegal: got %b want %b", illegal, ill); end
                if (ill && !redirect) halted = 1'b1;
`endif
                inst_exp = inst_exp + 32'(len);
            end
            if (mem_req && mem_ack && !redirect) begin
                checks++;
                if (mem_addr !== fetch_exp) begin
                    errors++;
                    $display("FAIL rnd_fetch_addr: addr=%h want %h", mem_addr, fetch_exp);
                end
                fetch_exp = fetch_exp + 32'd1;
            end
            if (redirect) begin
                inst_exp  = tgt;
                fetch_exp = tgt;
                halted    = 1'b0;
            end
            hold_prev = ope_valid && !ope_ready && !redirect;
            s_ope = ope; s_num = num_of_ope; s_pc = ope_pc;
            tick();
        end
        redirect = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h55;
        mem[0] = 8'h55; mem[1] = 8'h89; mem[2] = 8'he5;
        reset_n     = 1'b0;
        ope_ready   = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        mem_ack     = 1'b0;
        mem_data    = 8'h0;
        test_reset();
        test_basic();
        test_long();
        test_modrm();
        test_hold();
        test_redirect();
        test_handshake_redirect();
        test_illegal();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
